// File: rtl/median_window_feeder_pkg.sv
// Shared constants and the window-size decode for the variable-size median datapath.
// Downstream stages import wsize() so every stage maps a size code to taps identically.
package median_window_feeder_pkg;

    localparam int unsigned DataLength = 8;
    localparam int unsigned MaxWin     = 9;

    typedef enum logic [1:0] {
        Win3 = 2'b00,
        Win5 = 2'b01,
        Win7 = 2'b10,
        Win9 = 2'b11
    } win_code_e;

    // Window width in taps for a size code: 3 + 2*code.
    function automatic logic [3:0] wsize(input logic [1:0] code);
        return 4'd3 + {1'b0, code, 1'b0};
    endfunction

endpackage

// File: rtl/median_window_feeder_if.sv
// Sample-in / eviction-out bundle between the feeder and its neighbours.
interface median_window_feeder_if;
    import median_window_feeder_pkg::*;

    logic                  in_valid;
    logic [DataLength-1:0] in_data;
    logic                  in_ready;
    logic [1:0]            win_size;
    logic                  flush;
    logic [DataLength-1:0] new_data;
    logic [DataLength-1:0] old_in1;
    logic [DataLength-1:0] old_in2;
    logic [DataLength-1:0] old_in3;
    logic [DataLength-1:0] old_in4;
    logic                  sel1;
    logic                  sel2;
    logic                  out_valid;
    logic [3:0]            fill_cnt;

    modport master (
        output in_valid, in_data, win_size, flush,
        input  in_ready, new_data, old_in1, old_in2, old_in3, old_in4,
        input  sel1, sel2, out_valid, fill_cnt
    );

    modport slave (
        input  in_valid, in_data, win_size, flush,
        output in_ready, new_data, old_in1, old_in2, old_in3, old_in4,
        output sel1, sel2, out_valid, fill_cnt
    );

endinterface

// File: rtl/median_window_feeder_tap_delay_line.sv
// Shift register of samples with enable and synchronous clear.
// Exposes only the even taps 2/4/6/8, i.e. the samples leaving a 3/5/7/9-wide window.
module median_window_feeder_tap_delay_line #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 9
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic                            clr_i,
    input  logic [Width-1:0]                d_i,
    output logic [3:0][Width-1:0]           even_taps_o
);

    logic [Depth-1:0][Width-1:0] taps_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            taps_q <= '0;
        end else if (en_i) begin
            taps_q <= {taps_q[Depth-2:0], d_i};
        end
    end

    assign even_taps_o = {taps_q[8], taps_q[6], taps_q[4], taps_q[2]};

endmodule

// File: rtl/median_window_feeder.sv
// Feeds the 4:1 data-select mux: delays accepted samples, reports the evicted one per
// window size, and tracks fill level and the latched window size.
module median_window_feeder
    import median_window_feeder_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    median_window_feeder_if.slave bus
);

    logic                            accept;
    logic [3:0]                      wsize_w;
    logic [3:0][DataLength-1:0]      even_taps;

    logic [3:0]                      fill_q, fill_d;
    logic [1:0]                      size_q, size_d;
    logic                            out_valid_q, out_valid_d;
    logic [DataLength-1:0]           new_q, new_d;
    logic [3:0][DataLength-1:0]      old_q, old_d;

    assign bus.in_ready = rst_n && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wsize_w      = wsize(size_q);

    median_window_feeder_tap_delay_line #(
        .Width (DataLength),
        .Depth (MaxWin)
    ) u_taps (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (accept),
        .clr_i       (bus.flush),
        .d_i         (bus.in_data),
        .even_taps_o (even_taps)
    );

    always_comb begin
        fill_d      = fill_q;
        size_d      = size_q;
        out_valid_d = 1'b0;
        new_d       = new_q;
        old_d       = old_q;
        if (bus.flush) begin
            fill_d = '0;
        end else begin
            // Size only latches while the window is empty, including the first accept.
            if (fill_q == 4'd0) begin
                size_d = bus.win_size;
            end
            if (accept) begin
                new_d       = bus.in_data;
                old_d       = even_taps;
                out_valid_d = (fill_q == wsize_w);
                if (fill_q < wsize_w) begin
                    fill_d = fill_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q      <= '0;
            size_q      <= '0;
            out_valid_q <= 1'b0;
            new_q       <= '0;
            old_q       <= '0;
        end else begin
            fill_q      <= fill_d;
            size_q      <= size_d;
            out_valid_q <= out_valid_d;
            new_q       <= new_d;
            old_q       <= old_d;
        end
    end

    assign bus.new_data  = new_q;
    assign bus.old_in1   = old_q[0];
    assign bus.old_in2   = old_q[1];
    assign bus.old_in3   = old_q[2];
    assign bus.old_in4   = old_q[3];
    assign bus.sel1      = size_q[1];
    assign bus.sel2      = size_q[0];
    assign bus.out_valid = out_valid_q;
    assign bus.fill_cnt  = fill_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Scenario bench for median_window_feeder with a history-based model and an output scoreboard.
module tb_median_window_feeder;
    import median_window_feeder_pkg::*;

    typedef struct packed {
        logic [DataLength-1:0] nd;
        logic [DataLength-1:0] o1;
        logic [DataLength-1:0] o2;
        logic [DataLength-1:0] o3;
        logic [DataLength-1:0] o4;
        logic [1:0]            sel;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    exp_t                  sb[$];
    logic [DataLength-1:0] hist[$];
    logic [3:0]            m_fill = '0;
    logic [1:0]            m_size = '0;
    logic                  m_evict = 1'b0;

    median_window_feeder_if bus ();

    median_window_feeder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [DataLength-1:0] tap(input int k);
        return (hist.size() > k) ? hist[k] : '0;
    endfunction

    // One clock of stimulus; the model advances on the same edge.
    task automatic cycle(input logic v, input logic [DataLength-1:0] d, input logic fl,
                         input logic [1:0] ws);
        logic [3:0] wsz;
        exp_t       e;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = fl;
        bus.win_size = ws;
        @(posedge clk);
        m_evict = 1'b0;
        if (!rst_n) begin
            hist.delete();
            m_fill = '0;
            m_size = '0;
        end else if (fl) begin
            hist.delete();
            m_fill = '0;
        end else begin
            if (m_fill == 4'd0) m_size = ws;
            wsz = 4'(3 + 2 * int'(m_size));
            if (v) begin
                m_evict = (m_fill == wsz);
                if (m_evict) begin
                    e.nd  = d;
                    e.o1  = tap(2);
                    e.o2  = tap(4);
                    e.o3  = tap(6);
                    e.o4  = tap(8);
                    e.sel = m_size;
                    sb.push_back(e);
                end
                hist.push_front(d);
                if (hist.size() > 9) void'(hist.pop_back());
                if (m_fill < wsz) m_fill = m_fill + 4'd1;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            exp_t got;
            exp_t want;
            got = {bus.new_data, bus.old_in1, bus.old_in2, bus.old_in3, bus.old_in4,
                   bus.sel1, bus.sel2};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: out_valid with no expected eviction, got %h", got);
            end else begin
                want = sb.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL scoreboard: got %h want %h", got, want);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b1, 8'h55, 1'b0, 2'b11);
        cycle(1'b1, 8'h56, 1'b0, 2'b11);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        checks++;
        if ({bus.out_valid, bus.fill_cnt, bus.sel1, bus.sel2} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got ov=%b fill=%0d sel=%b%b want all 0",
                     bus.out_valid, bus.fill_cnt, bus.sel1, bus.sel2);
        end
        checks++;
        if ({bus.new_data, bus.old_in1, bus.old_in2, bus.old_in3, bus.old_in4} !== '0) begin
            errors++;
            $display("FAIL reset_data: got nd=%h o=%h %h %h %h want 0", bus.new_data,
                     bus.old_in1, bus.old_in2, bus.old_in3, bus.old_in4);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_win3();
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 2'b00);
            checks++;
            if (bus.out_valid !== m_evict || bus.fill_cnt !== m_fill) begin
                errors++;
                $display("FAIL win3_ctrl[%0d]: got ov=%b fill=%0d want ov=%b fill=%0d", i,
                         bus.out_valid, bus.fill_cnt, m_evict, m_fill);
            end
            if (i == 4) begin
                checks++;
                if ({bus.new_data, bus.old_in1, bus.sel1, bus.sel2} !== {8'd4, 8'd1, 2'b00}) begin
                    errors++;
                    $display("FAIL win3_s4: got nd=%0d o1=%0d sel=%b%b want 4 1 00",
                             bus.new_data, bus.old_in1, bus.sel1, bus.sel2);
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.old_in1 !== 8'd2) begin
                    errors++; $display("FAIL win3_s5: got o1=%0d want 2", bus.old_in1);
                end
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 2'b00);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL win3_idle: got ov=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_win9();
        cycle(1'b0, 8'h00, 1'b1, 2'b11);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(10 + i), 1'b0, 2'b11);
            checks++;
            if (bus.out_valid !== (i == 9)) begin
                errors++;
                $display("FAIL win9_ov[%0d]: got %b want %b", i, bus.out_valid, (i == 9));
            end
        end
        checks++;
        if ({bus.old_in4, bus.sel1, bus.sel2, bus.fill_cnt} !== {8'd10, 2'b11, 4'd9}) begin
            errors++;
            $display("FAIL win9_final: got o4=%0d sel=%b%b fill=%0d want 10 11 9",
                     bus.old_in4, bus.sel1, bus.sel2, bus.fill_cnt);
        end
    endtask

    task automatic test_size_lock();
        cycle(1'b0, 8'h00, 1'b1, 2'b01);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 2'b01);
        cycle(1'b0, 8'h00, 1'b0, 2'b10);
        cycle(1'b0, 8'h00, 1'b0, 2'b10);
        checks++;
        if ({bus.sel1, bus.sel2, bus.fill_cnt} !== {2'b01, 4'd3}) begin
            errors++;
            $display("FAIL size_locked: got sel=%b%b fill=%0d want 01 3",
                     bus.sel1, bus.sel2, bus.fill_cnt);
        end
        cycle(1'b0, 8'h00, 1'b1, 2'b10);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'h30 + i), 1'b0, 2'b10);
            checks++;
            if (bus.out_valid !== (i == 7)) begin
                errors++;
                $display("FAIL size7_ov[%0d]: got %b want %b", i, bus.out_valid, (i == 7));
            end
        end
        checks++;
        if ({bus.sel1, bus.sel2} !== 2'b10) begin
            errors++; $display("FAIL size_reload: got sel=%b%b want 10", bus.sel1, bus.sel2);
        end
    endtask

    task automatic test_flush_drop();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        bus.flush    = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready: got %b want 0", bus.in_ready);
        end
        cycle(1'b1, 8'hAA, 1'b1, 2'b00);
        checks++;
        if ({bus.fill_cnt, bus.out_valid, bus.new_data} !== {4'd0, 1'b0, 8'h37}) begin
            errors++;
            $display("FAIL flush_state: got fill=%0d ov=%b nd=%h want 0 0 37",
                     bus.fill_cnt, bus.out_valid, bus.new_data);
        end
        cycle(1'b1, 8'hAA, 1'b1, 2'b00);
        checks++;
        if (bus.fill_cnt !== 4'd0) begin
            errors++; $display("FAIL flush_twice: got fill=%0d want 0", bus.fill_cnt);
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h61 + i), 1'b0, 2'b00);
        checks++;
        if ({bus.old_in1, bus.old_in2, bus.old_in3} !== {8'h61, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL flush_dropped: got o1=%h o2=%h o3=%h want 61 00 00",
                     bus.old_in1, bus.old_in2, bus.old_in3);
        end
    endtask

    task automatic test_gaps();
        logic [DataLength-1:0] held;
        cycle(1'b0, 8'h00, 1'b1, 2'b00);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 8'(8'h80 + k), 1'b0, 2'b00);
            checks++;
            if (bus.out_valid !== m_evict) begin
                errors++;
                $display("FAIL gap_ov[%0d]: got %b want %b", k, bus.out_valid, m_evict);
            end
            held = bus.old_in1;
            for (int g = 0; g < 2; g++) begin
                cycle(1'b0, 8'hFF, 1'b0, 2'b00);
                checks++;
                if (bus.out_valid !== 1'b0 || bus.old_in1 !== held) begin
                    errors++;
                    $display("FAIL gap_hold[%0d]: got ov=%b o1=%h want 0 %h", k,
                             bus.out_valid, bus.old_in1, held);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 8'h00, 1'b1, 2'b10);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 2'b10);
        checks++;
        if (bus.fill_cnt !== 4'd7) begin
            errors++; $display("FAIL mid_fill: got %0d want 7", bus.fill_cnt);
        end
        rst_n = 1'b0;
        cycle(1'b1, 8'hEE, 1'b0, 2'b10);
        checks++;
        if ({bus.new_data, bus.old_in1, bus.old_in2, bus.old_in3, bus.old_in4, bus.sel1,
             bus.sel2, bus.out_valid, bus.fill_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got nd=%h o=%h %h %h %h sel=%b%b ov=%b fill=%0d want 0",
                     bus.new_data, bus.old_in1, bus.old_in2, bus.old_in3, bus.old_in4,
                     bus.sel1, bus.sel2, bus.out_valid, bus.fill_cnt);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(8'hD0 + i), 1'b0, 2'b10);
            checks++;
            if (bus.out_valid !== (i == 7)) begin
                errors++;
                $display("FAIL refill_ov[%0d]: got %b want %b", i, bus.out_valid, (i == 7));
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        bus.win_size = 2'b00;
        test_reset();
        test_win3();
        test_win9();
        test_size_lock();
        test_flush_drop();
        test_gaps();
        test_reset_mid();
        cycle(1'b0, 8'h00, 1'b0, 2'b00);
        cycle(1'b0, 8'h00, 1'b0, 2'b00);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
